wb_write_queue: RTL and testbench
=================================

# wb_write_queue

Write-back request buffer between the MEM/WB pipeline register and the register-file write port. It accepts register write requests over a valid/ready handshake and queues them in a small FIFO. It drains one request per cycle into registered `wr_en`/`wr_addr`/`wr_data` outputs, and `wr_addr` feeds the register-file write-address decode tree. Writes to X31 (zero register) are consumed and discarded, never issued.

## Interface
- `DEPTH`, 2 — FIFO entries; power of two, 2..8.
- `DW`, 64 — data width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `in_addr`  in  5  destination register index.
- `in_data`  in  DW  write data.
- `wr_stall`  in  1  register-file port blocked this cycle; no pop.
- `wr_en`  out  1  registered write strobe, one cycle per issued write.
- `wr_addr`  out  5  registered write index.
- `wr_data`  out  DW  registered write data.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `drop_cnt`  out  8  X31 writes discarded; wraps 255→0.
- `rd_addr`  in  5  forwarding lookup index (WB_FWD_EN only).
- `fwd_hit`  out  1  lookup matched (WB_FWD_EN only).
- `fwd_data`  out  DW  forwarded value (WB_FWD_EN only).

## Operation
- Push: at a rising edge with `in_valid && in_ready`. If `in_addr == 31`, no entry is written and `drop_cnt` increments. Otherwise `{in_addr, in_data}` is written at the tail and the tail pointer advances modulo DEPTH.
- `in_ready` depends only on `count` (`count != DEPTH`). A pop in the same cycle does not allow a push into a full buffer.
- Pop: at a rising edge with `count != 0 && !wr_stall`. The head is loaded into `wr_addr`/`wr_data`, `wr_en` is set to 1 for the following cycle, and the head advances.
- When no pop occurs, `wr_en` is cleared to 0 at the edge. `wr_addr`/`wr_data` hold their last values.
- Simultaneous push and pop in a non-full buffer: `count` is unchanged and both pointers advance.
- A push into an empty buffer is not popped at the same edge. There is no bypass from input to output.
- Ordering is strict FIFO. Two queued writes to the same index issue in arrival order.
- `count` is updated at every edge: +1 for a push of a non-X31 request, −1 for a pop.

## Timing
- Reset (asynchronous assert, release on a `clk` edge): `wr_en=0`, `wr_addr=0`, `wr_data=0`, `count=0`, `drop_cnt=0`, `fwd_hit=0`, `fwd_data=0`, pointers 0. `in_ready=1` while reset is deasserted and the buffer is empty.
- Reset mid-operation: all queued entries are lost and no further `wr_en` pulse is issued. Asserting reset clears `wr_en` asynchronously.
- Latency: a request accepted at edge N into an empty, unstalled buffer gives `wr_en=1` after edge N+1, for one cycle.
- Throughput: one write per cycle sustained when `wr_stall=0`.
- `wr_stall` is sampled at the edge. A stall blocks the pop but does not retract a `wr_en` already being driven.

## Configuration
- `WB_FWD_EN` defined: `rd_addr` is compared combinationally against all valid entries and against the in-flight output (`wr_en && wr_addr`).
  - `fwd_hit=1` on any match. `fwd_data` takes the youngest match; the queue outranks the output register.
  - `rd_addr == 31` never hits.
- `WB_FWD_EN` undefined: `fwd_hit` and `fwd_data` are tied to 0, `rd_addr` is ignored, and no comparators are generated.

## Test plan
- Reset, then a single push of addr=5, data=0xAA with `wr_stall=0` → `wr_en=1`, `wr_addr=5`, `wr_data=0xAA` for exactly one cycle, one cycle after acceptance. `count` reads 1 and then 0.
- Hold `wr_stall=1` and push addrs 1 and 2 (DEPTH=2) → `in_ready=0`, `count=2`, and a third push is not accepted. Release the stall → writes to 1 and then 2 issue on consecutive cycles, and `in_ready` returns to 1.
- Push addr=31 three times → no `wr_en`, `count=0`, `drop_cnt=3`. Then push 256 more X31 requests → `drop_cnt` wraps to 3.
- Continuous push of addrs 0..9 with `count` held at 1 → ten consecutive `wr_en` pulses, in order, with no loss.
- Assert `rst_n=0` with 2 entries queued and `wr_en` high → `wr_en` drops immediately. After release, `count=0` and no writes issue.
- WB_FWD_EN: stall, push {3,0x11} then {3,0x22}, and set `rd_addr=3` → `fwd_hit=1`, `fwd_data=0x22`. Set `rd_addr=31` → `fwd_hit=0`. In a build without the macro → `fwd_hit=0` always.

Source files
------------

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//
// Write-back request buffer between the MEM/WB pipeline register and the
// register-file write port. Requests arrive over a valid/ready handshake, are
// queued in a small FIFO, and drain one per cycle into registered
// wr_en/wr_addr/wr_data outputs. Writes to X31 (zero register) are accepted,
// counted in drop_cnt, and never queued or issued.
//
// Optional feature macro: WB_FWD_EN
//   defined   : rd_addr is compared against every valid queue entry and the
//               in-flight output register; fwd_hit/fwd_data report the
//               youngest match (queue entries outrank the output register).
//   undefined : fwd_hit/fwd_data tied to 0, rd_addr ignored.
//
// Parameters
//   DEPTH  FIFO entries, power of two in 2..8
//   DW     data width
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   request present
//   in_ready  out  buffer can accept (count != DEPTH)
//   in_addr   in   destination register index
//   in_data   in   write data
//   wr_stall  in   register-file port blocked, no pop this edge
//   wr_en     out  registered write strobe
//   wr_addr   out  registered write index
//   wr_data   out  registered write data
//   count     out  occupied entries
//   drop_cnt  out  discarded X31 writes, wraps at 256
//   rd_addr   in   forwarding lookup index
//   fwd_hit   out  forwarding lookup matched
//   fwd_data  out  forwarded value
// -----------------------------------------------------------------------------
module wb_write_queue #(
    parameter int DEPTH = 2,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     wr_stall,
    output logic                     wr_en,
    output logic [4:0]               wr_addr,
    output logic [DW-1:0]            wr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt,
    input  logic [4:0]               rd_addr,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] ZERO_REG = 5'd31;

    // Queue storage; not reset, validity is tracked by head/count.
    logic [4:0]    mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [7:0]    drop_cnt_reg;
    logic          wr_en_reg;
    logic [4:0]    wr_addr_reg;
    logic [DW-1:0] wr_data_reg;

    logic push_fire;
    logic push_drop;
    logic push_en;
    logic pop_en;

    // Ready depends only on occupancy: a same-cycle pop never frees a slot
    // for a push into a full buffer.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign push_fire = in_valid && in_ready;
    assign push_drop = push_fire && (in_addr == ZERO_REG);
    assign push_en   = push_fire && (in_addr != ZERO_REG);
    // Pop looks at the pre-edge count, so a push into an empty buffer is
    // never bypassed to the output at the same edge.
    assign pop_en    = (count_reg != '0) && !wr_stall;

    assign count_next = count_reg + CW'(push_en) - CW'(pop_en);

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_addr[tail_reg] <= in_addr;
            mem_data[tail_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push_en) begin
                tail_reg <= tail_reg + AW'(1);
            end
            if (push_drop) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
            wr_en_reg <= pop_en;
            if (pop_en) begin
                wr_addr_reg <= mem_addr[head_reg];
                wr_data_reg <= mem_data[head_reg];
                head_reg    <= head_reg + AW'(1);
            end
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign count    = count_reg;
    assign drop_cnt = drop_cnt_reg;

`ifdef WB_FWD_EN
    // Per-slot match: slot is valid when its age behind head is < count.
    logic [DEPTH-1:0] slot_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] age;
            assign age            = AW'(gi) - head_reg;
            assign slot_match[gi] = ({1'b0, age} < count_reg) &&
                                    (mem_addr[gi] == rd_addr);
        end
    endgenerate

    logic          fwd_hit_c;
    logic [DW-1:0] fwd_data_c;
    logic [AW-1:0] idx;

    // Output register first, then queue entries oldest to youngest, so the
    // youngest match wins and any queue match outranks the output register.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        idx        = '0;
        if (rd_addr != ZERO_REG) begin
            if (wr_en_reg && (wr_addr_reg == rd_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = wr_data_reg;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_reg + AW'(k);
                if (slot_match[idx]) begin
                    fwd_hit_c  = 1'b1;
                    fwd_data_c = mem_data[idx];
                end
            end
        end
    end

    assign fwd_hit  = fwd_hit_c;
    assign fwd_data = fwd_data_c;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_write_queue
//
// Self-checking bench for wb_write_queue (DEPTH=2, DW=64). A queue-based
// reference model predicts every output each cycle; directed sequences cover
// latency, back-pressure, X31 dropping and wrap, streaming, mid-operation
// reset and forwarding, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_wb_write_queue;

    localparam int DEPTH = 2;
    localparam int DW    = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [DW-1:0] in_data;
    logic          wr_stall;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] count;
    logic [7:0]    drop_cnt;
    logic [4:0]    rd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    wb_write_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_stall (wr_stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .count    (count),
        .drop_cnt (drop_cnt),
        .rd_addr  (rd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending writes as queues, plus the output register.
    logic [4:0]  qa[$];
    logic [63:0] qd[$];
    logic        m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [63:0] m_wr_data;
    logic [7:0]  m_drop;

    task automatic model_reset();
        qa.delete();
        qd.delete();
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_drop    = '0;
    endtask

    // One clock edge of the rules: pop decided from pre-edge occupancy,
    // push accepted only when not full, X31 counted instead of queued.
    task automatic model_step(input logic v, input logic [4:0] a,
                              input logic [63:0] d, input logic s);
        int  sz;
        bit  rdy;
        sz  = qa.size();
        rdy = (sz != DEPTH);
        if (sz != 0 && !s) begin
            m_wr_en   = 1'b1;
            m_wr_addr = qa.pop_front();
            m_wr_data = qd.pop_front();
        end else begin
            m_wr_en = 1'b0;
        end
        if (v && rdy) begin
            if (a == 5'd31) begin
                m_drop = m_drop + 8'd1;
            end else begin
                qa.push_back(a);
                qd.push_back(d);
            end
        end
    endtask

    task automatic check_all(input logic [4:0] r);
        logic        e_hit;
        logic [63:0] e_data;
        e_hit  = 1'b0;
        e_data = '0;
`ifdef WB_FWD_EN
        if (r != 5'd31) begin
            for (int i = qa.size() - 1; i >= 0; i--) begin
                if (!e_hit && qa[i] == r) begin
                    e_hit  = 1'b1;
                    e_data = qd[i];
                end
            end
            if (!e_hit && m_wr_en && m_wr_addr == r) begin
                e_hit  = 1'b1;
                e_data = m_wr_data;
            end
        end
`endif
        check_val("wr_en",    64'(wr_en),    64'(m_wr_en));
        check_val("wr_addr",  64'(wr_addr),  64'(m_wr_addr));
        check_val("wr_data",  wr_data,       m_wr_data);
        check_val("count",    64'(count),    64'(qa.size()));
        check_val("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check_val("in_ready", 64'(in_ready), 64'(qa.size() != DEPTH));
        check_val("fwd_hit",  64'(fwd_hit),  64'(e_hit));
        check_val("fwd_data", fwd_data,      e_data);
        if (m_wr_en) begin
            $display("issue addr=%0d data=%0h count=%0d", wr_addr, wr_data, count);
        end
    endtask

    // Called at a falling edge: drive inputs, check, take one rising edge,
    // advance the model, and return at the next falling edge.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [63:0] d,
                         input logic s, input logic [4:0] r);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wr_stall = s;
        rd_addr  = r;
        #1;
        check_all(r);
        @(posedge clk);
        model_step(v, a, d, s);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        wr_stall = 1'b0;
        rd_addr  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset values, then single push with one-cycle latency.
        cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        cycle(1'b1, 5'd5, 64'hAA, 1'b0, 5'd5);
        check_val("lat_count1", 64'(count), 64'd1);
        cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd5);
        check_val("lat_wr_en", 64'(wr_en), 64'd1);
        check_val("lat_wr_addr", 64'(wr_addr), 64'd5);
        check_val("lat_wr_data", wr_data, 64'hAA);
        cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        check_val("lat_one_pulse", 64'(wr_en), 64'd0);

        // Back-pressure: fill under stall, third push refused, then drain.
        cycle(1'b1, 5'd1, 64'h101, 1'b1, 5'd0);
        cycle(1'b1, 5'd2, 64'h202, 1'b1, 5'd0);
        check_val("full_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 5'd3, 64'h303, 1'b1, 5'd0);
        check_val("full_count", 64'(count), 64'd2);
        repeat (4) cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);

        // X31 drops and drop counter wrap.
        repeat (3) cycle(1'b1, 5'd31, 64'hDEAD, 1'b0, 5'd0);
        check_val("drop3", 64'(drop_cnt), 64'd3);
        repeat (256) cycle(1'b1, 5'd31, 64'(32'($urandom)), 1'b0, 5'd0);
        check_val("drop_wrap", 64'(drop_cnt), 64'd3);

        // Streaming: ten back-to-back writes.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'(i), 64'h1000 + 64'(i), 1'b0, 5'(i));
        end
        repeat (3) cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);

        // Mid-operation reset while a write is being driven.
        cycle(1'b1, 5'd7, 64'h77, 1'b1, 5'd0);
        cycle(1'b1, 5'd8, 64'h88, 1'b1, 5'd0);
        in_valid = 1'b0;
        wr_stall = 1'b0;
        @(posedge clk);
        model_step(1'b0, 5'd0, 64'h0, 1'b0);
        #2;
        check_val("rst_pre_wr_en", 64'(wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_async_wr_en", 64'(wr_en), 64'd0);
        check_val("rst_async_count", 64'(count), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);

        // Forwarding: youngest queued match wins, X31 never hits.
        cycle(1'b1, 5'd3, 64'h11, 1'b1, 5'd3);
        cycle(1'b1, 5'd3, 64'h22, 1'b1, 5'd3);
        cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd3);
`ifdef WB_FWD_EN
        check_val("fwd_young_hit", 64'(fwd_hit), 64'd1);
        check_val("fwd_young_data", fwd_data, 64'h22);
`else
        check_val("fwd_off_hit", 64'(fwd_hit), 64'd0);
`endif
        cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd31);
        check_val("fwd_x31", 64'(fwd_hit), 64'd0);
        repeat (3) cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd3);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            int          ra;
            int          rr;
            logic [4:0]  a;
            logic [4:0]  r;
            ra = $urandom_range(0, 9);
            rr = $urandom_range(0, 9);
            a  = (ra >= 8) ? 5'd31 : 5'(ra);
            r  = (rr >= 8) ? 5'd31 : 5'(rr);
            cycle(1'($urandom_range(0, 3) != 0), a,
                  {32'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 3) == 0), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
